display_source_sched: RTL

DISPLAY_SOURCE_SCHED -- requirements
Module: display_source_sched

---
 rtl/display_source_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/display_source_sched.sv
// Multiplexed 4-digit BCD display scheduler: song digits live, note digits latched and held after the last request.
// Optional LEADING_ZERO_BLANK_EN blanks the leading-zero positions while a source is lit.
module display_source_sched #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       note_req,
  input  logic       song_active,
  input  logic [3:0] note_ones,
  input  logic [3:0] note_tens,
  input  logic [3:0] note_hund,
  input  logic [3:0] note_thou,
  input  logic [3:0] song_ones,
  input  logic [3:0] song_tens,
  input  logic [3:0] song_hund,
  input  logic [3:0] song_thou,
  output logic       audio_sel,
  output logic [3:0] digit,
  output logic [3:0] anode
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SONG = 2'd1;
  localparam logic [1:0] ST_NOTE = 2'd2;

  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic [15:0]   r_note;
  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [3:0]    r_digit;
  logic [3:0]    r_anode;

  logic [1:0]    w_state_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [15:0]   w_src;
  logic [3:0]    w_sel_dig;
  logic [3:0]    w_blank;
  logic [3:0]    w_anode_lit;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (note_req) begin
          w_state_nxt = ST_NOTE;
          w_hold_nxt  = HOLD_LOAD;
        end else if (song_active) begin
          w_state_nxt = ST_SONG;
        end
      end
      ST_SONG: begin
        if (note_req) begin
          w_state_nxt = ST_NOTE;
          w_hold_nxt  = HOLD_LOAD;
        end else if (!song_active) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_NOTE: begin
        if (note_req) begin
          w_hold_nxt = HOLD_LOAD;
        end else if (r_hold == '0) begin
          w_state_nxt = song_active ? ST_SONG : ST_IDLE;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Note display always comes from the latch so the value survives the key release.
  assign w_src = (r_state == ST_NOTE) ? r_note
                                      : {song_thou, song_hund, song_tens, song_ones};

  always_comb begin
    w_sel_dig = 4'h0;
    case (r_idx)
      2'd0:    w_sel_dig = w_src[3:0];
      2'd1:    w_sel_dig = w_src[7:4];
      2'd2:    w_sel_dig = w_src[11:8];
      default: w_sel_dig = w_src[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = {w_src[15:12] == 4'h0, w_src[15:8] == 8'h0, w_src[15:4] == 12'h0, 1'b0};
`else
  assign w_blank = 4'b0000;
`endif

  assign w_anode_lit = ~(4'b0001 << r_idx) | w_blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_note  <= 16'h0;
      r_div   <= '0;
      r_idx   <= 2'd0;
      r_digit <= 4'h0;
      r_anode <= 4'b1111;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      if (note_req) begin
        r_note <= {note_thou, note_hund, note_tens, note_ones};
      end
      // Scan keeps running across state changes so the refresh cadence never jitters.
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (r_state == ST_IDLE) begin
        r_digit <= 4'h0;
        r_anode <= 4'b1111;
      end else begin
        r_digit <= w_sel_dig;
        r_anode <= w_anode_lit;
      end
    end
  end

  assign audio_sel = (r_state == ST_NOTE);
  assign digit     = r_digit;
  assign anode     = r_anode;

endmodule
